// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage: one shift-add or
// restoring-divide step per cycle, with a registered single-cycle result pulse.
module execute_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StartE,
   input  logic [2:0]       MulDivOpE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic [4:0]       RdE,
   input  logic             FlushE,
   output logic             StallE,
   output logic             ValidM,
   output logic [WIDTH-1:0] ResultM,
   output logic [4:0]       RdM
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [4:0]         rd_q, rd_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   bmag_q, bmag_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [4:0]         rd_m_q, rd_m_d;
   logic               valid_q, valid_d;

   logic               a_signed, b_signed, neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b, special_res;
   logic               div_zero, div_ovf, accept;
   logic [WIDTH:0]     mul_sum, div_top, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

   assign StallE  = (StartE && !FlushE && state_q != BUSY) || (state_q == BUSY && !FlushE);
   assign ValidM  = valid_q;
   assign ResultM = result_q;
   assign RdM     = rd_m_q;

   always_comb begin
      a_signed = MulDivOpE[2] ? !MulDivOpE[0] : (MulDivOpE[1:0] == 2'b01 || MulDivOpE[1:0] == 2'b10);
      b_signed = MulDivOpE[2] ? !MulDivOpE[0] : (MulDivOpE[1:0] == 2'b01);
      neg_a    = a_signed && SrcAE[WIDTH-1];
      neg_b    = b_signed && SrcBE[WIDTH-1];
      mag_a    = neg_a ? -SrcAE : SrcAE;
      mag_b    = neg_b ? -SrcBE : SrcBE;
      div_zero = MulDivOpE[2] && (SrcBE == '0);
      div_ovf  = MulDivOpE[2] && !MulDivOpE[0] && (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcBE == '1);
      if (div_zero) special_res = MulDivOpE[1] ? SrcAE : '1;
      else          special_res = MulDivOpE[1] ? '0 : SrcAE;
      accept = StartE && !FlushE && (state_q != BUSY);

      // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Divide: the shifted partial remainder needs WIDTH+1 bits before the compare.
      div_top  = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_top - {1'b0, bmag_q};
      div_ge   = !div_diff[WIDTH];
      div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

      step_next = op_q[2] ? div_next : mul_next;
      prod_fix  = (sign_a_q ^ sign_b_q) ? -step_next : step_next;
      quo_fix   = (sign_a_q ^ sign_b_q) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
      rem_fix   = sign_a_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
      if (!op_q[2]) final_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
      else          final_res = op_q[1] ? rem_fix : quo_fix;

      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      rd_d     = rd_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      acc_d    = acc_q;
      bmag_d   = bmag_q;
      result_d = result_q;
      rd_m_d   = rd_m_q;
      valid_d  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               op_d     = MulDivOpE;
               rd_d     = RdE;
               sign_a_d = neg_a;
               sign_b_d = neg_b;
               bmag_d   = mag_b;
               acc_d    = {{WIDTH{1'b0}}, mag_a};
               cnt_d    = '0;
               if (div_zero || div_ovf) begin
                  result_d = special_res;
                  rd_m_d   = RdE;
                  valid_d  = 1'b1;
                  state_d  = DONE;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (FlushE) begin
               state_d = IDLE;
            end else begin
               acc_d = step_next;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) begin
                  result_d = final_res;
                  rd_m_d   = rd_q;
                  valid_d  = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         acc_q    <= '0;
         bmag_q   <= '0;
         result_q <= '0;
         rd_m_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         acc_q    <= acc_d;
         bmag_q   <= bmag_d;
         result_q <= result_d;
         rd_m_q   <= rd_m_d;
         valid_q  <= valid_d;
      end
   end
endmodule
